pipeline_hazard_ctrl: RTL and testbench

Central stall/flush/forwarding controller for the 5-stage RISC-V pipeline (IF→PR1→ID→PR2→EX→PR3→MEM→PR4→WB).
- Drives the hold (busywait) inputs of PR1–PR3, per-stage flush/bubble strobes and the PC hold.
- Detects load-use hazards and generates EX operand forwarding selects.
- Sequences data-cache freezes and branch redirects that overlap an outstanding instruction-cache miss.

---
 rtl/pipeline_hazard_ctrl_if.sv | 59 +++++
 rtl/pipeline_hazard_ctrl.sv | 159 +++++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipeline_hazard_ctrl_if.sv
// Pipeline-side signal bundle for the hazard controller.
// master = pipeline datapath, slave = pipeline_hazard_ctrl.
`timescale 1ns/1ps
interface pipeline_hazard_ctrl_if #(
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned CNT_W      = 16
);
    logic [REG_ADDR_W-1:0] id_rs1;
    logic [REG_ADDR_W-1:0] id_rs2;
    logic                  id_rs1_used;
    logic                  id_rs2_used;
    logic [REG_ADDR_W-1:0] ex_rs1;
    logic [REG_ADDR_W-1:0] ex_rs2;
    logic [REG_ADDR_W-1:0] ex_rd;
    logic                  ex_memRead;
    logic [REG_ADDR_W-1:0] mem_rd;
    logic                  mem_writeEnable;
    logic [REG_ADDR_W-1:0] wb_rd;
    logic                  wb_writeEnable;
    logic                  branch_taken;
    logic                  imem_busywait;
    logic                  dmem_busywait;

    logic                  pc_hold;
    logic                  pr1_hold;
    logic                  pr2_hold;
    logic                  pr3_hold;
    logic                  pr1_flush;
    logic                  pr2_flush;
    logic                  pr4_bubble;
    logic [1:0]            fwd_a_sel;
    logic [1:0]            fwd_b_sel;
    logic [1:0]            state;
    logic [CNT_W-1:0]      stall_cnt;
    logic [CNT_W-1:0]      freeze_cnt;
    logic [CNT_W-1:0]      flush_cnt;

    modport master (
        output id_rs1, id_rs2, id_rs1_used, id_rs2_used,
        output ex_rs1, ex_rs2, ex_rd, ex_memRead,
        output mem_rd, mem_writeEnable, wb_rd, wb_writeEnable,
        output branch_taken, imem_busywait, dmem_busywait,
        input  pc_hold, pr1_hold, pr2_hold, pr3_hold,
        input  pr1_flush, pr2_flush, pr4_bubble,
        input  fwd_a_sel, fwd_b_sel, state,
        input  stall_cnt, freeze_cnt, flush_cnt
    );

    modport slave (
        input  id_rs1, id_rs2, id_rs1_used, id_rs2_used,
        input  ex_rs1, ex_rs2, ex_rd, ex_memRead,
        input  mem_rd, mem_writeEnable, wb_rd, wb_writeEnable,
        input  branch_taken, imem_busywait, dmem_busywait,
        output pc_hold, pr1_hold, pr2_hold, pr3_hold,
        output pr1_flush, pr2_flush, pr4_bubble,
        output fwd_a_sel, fwd_b_sel, state,
        output stall_cnt, freeze_cnt, flush_cnt
    );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush/forwarding controller for the 5-stage RISC-V pipeline.
// Define HAZARD_PERF_CNT_EN to build the stall/freeze/flush performance counters.
`timescale 1ns/1ps
module pipeline_hazard_ctrl #(
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                 clock,
    input  logic                 reset,
    pipeline_hazard_ctrl_if.slave bus
);
    localparam logic [1:0] ST_RUN      = 2'b00;
    localparam logic [1:0] ST_FREEZE   = 2'b01;
    localparam logic [1:0] ST_REDIRECT = 2'b10;

    logic [1:0] state_q, state_d;
    logic       redirect_pending_q, redirect_pending_d;
    logic       lu_c;
    logic       pc_hold_c, pr1_hold_c, pr2_hold_c, pr3_hold_c;
    logic       pr1_flush_c, pr2_flush_c, pr4_bubble_c;

    // Nearest producer wins; x0 is never forwarded.
    function automatic logic [1:0] fwd_sel(
        input logic [REG_ADDR_W-1:0] rs,
        input logic [REG_ADDR_W-1:0] mem_rd,
        input logic                  mem_we,
        input logic [REG_ADDR_W-1:0] wb_rd,
        input logic                  wb_we
    );
        if (mem_we && (mem_rd != '0) && (mem_rd == rs)) return 2'b01;
        if (wb_we && (wb_rd != '0) && (wb_rd == rs))    return 2'b10;
        return 2'b00;
    endfunction

    assign lu_c = bus.ex_memRead && (bus.ex_rd != '0) &&
                  ((bus.id_rs1_used && (bus.id_rs1 == bus.ex_rd)) ||
                   (bus.id_rs2_used && (bus.id_rs2 == bus.ex_rd)));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q            <= ST_RUN;
            redirect_pending_q <= 1'b0;
        end else begin
            state_q            <= state_d;
            redirect_pending_q <= redirect_pending_d;
        end
    end

    always_comb begin
        state_d            = state_q;
        redirect_pending_d = redirect_pending_q;
        pc_hold_c          = 1'b0;
        pr1_hold_c         = 1'b0;
        pr2_hold_c         = 1'b0;
        pr3_hold_c         = 1'b0;
        pr1_flush_c        = 1'b0;
        pr2_flush_c        = 1'b0;
        pr4_bubble_c       = 1'b0;

        if (bus.dmem_busywait) begin
            // Data-cache freeze dominates everything, in any state.
            pc_hold_c    = 1'b1;
            pr1_hold_c   = 1'b1;
            pr2_hold_c   = 1'b1;
            pr3_hold_c   = 1'b1;
            pr4_bubble_c = 1'b1;
            state_d      = ST_FREEZE;
            if (state_q == ST_REDIRECT) redirect_pending_d = 1'b1;
        end else if (state_q == ST_REDIRECT) begin
            // Keep squashing the wrong-path fetch until the I-cache releases it.
            pr1_flush_c = 1'b1;
            pc_hold_c   = bus.imem_busywait;
            if (bus.branch_taken) begin
                pr2_flush_c = 1'b1;
            end else if (!bus.imem_busywait) begin
                state_d = ST_RUN;
            end
        end else begin
            state_d = ST_RUN;
            if (state_q == ST_FREEZE) begin
                redirect_pending_d = 1'b0;
                if (redirect_pending_q) state_d = ST_REDIRECT;
            end
            if (bus.branch_taken) begin
                pr1_flush_c = 1'b1;
                pr2_flush_c = 1'b1;
                if (bus.imem_busywait) state_d = ST_REDIRECT;
            end else if (lu_c) begin
                pc_hold_c   = 1'b1;
                pr1_hold_c  = 1'b1;
                pr2_flush_c = 1'b1;
            end else if (bus.imem_busywait) begin
                pc_hold_c   = 1'b1;
                pr1_flush_c = 1'b1;
            end
        end
    end

    // Flush beats hold on the same register; reset forces a clean pipe.
    always_comb begin
        bus.pc_hold    = pc_hold_c;
        bus.pr1_hold   = pr1_hold_c & ~pr1_flush_c;
        bus.pr2_hold   = pr2_hold_c & ~pr2_flush_c;
        bus.pr3_hold   = pr3_hold_c;
        bus.pr1_flush  = pr1_flush_c;
        bus.pr2_flush  = pr2_flush_c;
        bus.pr4_bubble = pr4_bubble_c;
        bus.fwd_a_sel  = fwd_sel(bus.ex_rs1, bus.mem_rd, bus.mem_writeEnable,
                                 bus.wb_rd, bus.wb_writeEnable);
        bus.fwd_b_sel  = fwd_sel(bus.ex_rs2, bus.mem_rd, bus.mem_writeEnable,
                                 bus.wb_rd, bus.wb_writeEnable);
        if (!reset) begin
            bus.pc_hold    = 1'b0;
            bus.pr1_hold   = 1'b0;
            bus.pr2_hold   = 1'b0;
            bus.pr3_hold   = 1'b0;
            bus.pr1_flush  = 1'b1;
            bus.pr2_flush  = 1'b1;
            bus.pr4_bubble = 1'b1;
            bus.fwd_a_sel  = 2'b00;
            bus.fwd_b_sel  = 2'b00;
        end
    end

    assign bus.state = state_q;

`ifdef HAZARD_PERF_CNT_EN
    logic [CNT_W-1:0] stall_cnt_q, freeze_cnt_q, flush_cnt_q;
    logic             stall_ev_c;

    // A load-use stall is only issued when the RUN rules are evaluated.
    assign stall_ev_c = lu_c && !bus.dmem_busywait && !bus.branch_taken &&
                        (state_q != ST_REDIRECT);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stall_cnt_q  <= '0;
            freeze_cnt_q <= '0;
            flush_cnt_q  <= '0;
        end else begin
            if (stall_ev_c && (stall_cnt_q != '1))
                stall_cnt_q <= stall_cnt_q + CNT_W'(1);
            if (bus.dmem_busywait && (freeze_cnt_q != '1))
                freeze_cnt_q <= freeze_cnt_q + CNT_W'(1);
            if (bus.branch_taken && !bus.dmem_busywait && (flush_cnt_q != '1))
                flush_cnt_q <= flush_cnt_q + CNT_W'(1);
        end
    end

    assign bus.stall_cnt  = stall_cnt_q;
    assign bus.freeze_cnt = freeze_cnt_q;
    assign bus.flush_cnt  = flush_cnt_q;
`else
    assign bus.stall_cnt  = CNT_W'(0);
    assign bus.freeze_cnt = CNT_W'(0);
    assign bus.flush_cnt  = CNT_W'(0);
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Randomized and directed bench for pipeline_hazard_ctrl against a rule-level reference model.
`timescale 1ns/1ps
module tb_pipeline_hazard_ctrl;
    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned CNT_W      = 16;
    localparam int CNT_MAX = (1 << CNT_W) - 1;
    localparam int M_RUN = 0, M_FREEZE = 1, M_REDIRECT = 2;
`ifdef HAZARD_PERF_CNT_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    pipeline_hazard_ctrl_if #(.REG_ADDR_W(REG_ADDR_W), .CNT_W(CNT_W)) bus ();
    pipeline_hazard_ctrl #(.REG_ADDR_W(REG_ADDR_W), .CNT_W(CNT_W)) dut (
        .clock(clk), .reset(rst_n), .bus(bus)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model state: pipeline mode, deferred redirect, counter tallies.
    int m_mode;
    bit m_pend;
    int m_stall, m_freeze, m_flush;
    bit e_pc, e_h1, e_h2, e_h3, e_f1, e_f2, e_b4;
    int e_fa, e_fb, n_mode;
    bit n_pend, ev_stall;

    function automatic int fwd_src(int rs, bit mwe, int mrd, bit wwe, int wrd);
        if (mwe && mrd != 0 && mrd == rs) return 1;
        if (wwe && wrd != 0 && wrd == rs) return 2;
        return 0;
    endfunction

    task automatic model_eval();
        bit lu;
        string rule;
        lu = bus.ex_memRead && bus.ex_rd != 0 &&
             ((bus.id_rs1_used && bus.id_rs1 == bus.ex_rd) ||
              (bus.id_rs2_used && bus.id_rs2 == bus.ex_rd));
        n_mode = m_mode; n_pend = m_pend; ev_stall = 0;
        if (bus.dmem_busywait)                   rule = "freeze";
        else if (m_mode == M_REDIRECT)           rule = "wrongpath";
        else if (bus.branch_taken)               rule = "branch";
        else if (lu)                             rule = "loaduse";
        else if (bus.imem_busywait)              rule = "ifetch";
        else                                     rule = "none";
        // Leaving FREEZE through the RUN rules resolves any deferred redirect.
        if (rule != "freeze" && rule != "wrongpath") begin
            n_mode = (m_mode == M_FREEZE && m_pend) ? M_REDIRECT : M_RUN;
            if (m_mode == M_FREEZE) n_pend = 0;
        end
        {e_pc, e_h1, e_h2, e_h3, e_f1, e_f2, e_b4} = 7'b0;
        case (rule)
            "freeze": begin
                {e_pc, e_h1, e_h2, e_h3, e_b4} = 5'b11111;
                n_mode = M_FREEZE;
                if (m_mode == M_REDIRECT) n_pend = 1;
            end
            "wrongpath": begin
                e_f1 = 1; e_pc = bus.imem_busywait; e_f2 = bus.branch_taken;
                if (!bus.branch_taken && !bus.imem_busywait) n_mode = M_RUN;
            end
            "branch": begin
                e_f1 = 1; e_f2 = 1;
                if (bus.imem_busywait) n_mode = M_REDIRECT;
            end
            "loaduse": begin e_pc = 1; e_h1 = 1; e_f2 = 1; ev_stall = 1; end
            "ifetch":  begin e_pc = 1; e_f1 = 1; end
            default: ;
        endcase
        e_fa = fwd_src(int'(bus.ex_rs1), bus.mem_writeEnable, int'(bus.mem_rd),
                       bus.wb_writeEnable, int'(bus.wb_rd));
        e_fb = fwd_src(int'(bus.ex_rs2), bus.mem_writeEnable, int'(bus.mem_rd),
                       bus.wb_writeEnable, int'(bus.wb_rd));
        if (!rst_n) begin
            {e_pc, e_h1, e_h2, e_h3} = 4'b0;
            {e_f1, e_f2, e_b4} = 3'b111;
            e_fa = 0; e_fb = 0;
        end
    endtask

    task automatic check_all();
        check_eq("pc_hold",    32'(bus.pc_hold),    32'(e_pc));
        check_eq("pr1_hold",   32'(bus.pr1_hold),   32'(e_h1));
        check_eq("pr2_hold",   32'(bus.pr2_hold),   32'(e_h2));
        check_eq("pr3_hold",   32'(bus.pr3_hold),   32'(e_h3));
        check_eq("pr1_flush",  32'(bus.pr1_flush),  32'(e_f1));
        check_eq("pr2_flush",  32'(bus.pr2_flush),  32'(e_f2));
        check_eq("pr4_bubble", 32'(bus.pr4_bubble), 32'(e_b4));
        check_eq("fwd_a_sel",  32'(bus.fwd_a_sel),  32'(e_fa));
        check_eq("fwd_b_sel",  32'(bus.fwd_b_sel),  32'(e_fb));
        check_eq("state",      32'(bus.state),      32'(m_mode));
        check_eq("stall_cnt",  32'(bus.stall_cnt),  PERF ? 32'(m_stall)  : 32'd0);
        check_eq("freeze_cnt", 32'(bus.freeze_cnt), PERF ? 32'(m_freeze) : 32'd0);
        check_eq("flush_cnt",  32'(bus.flush_cnt),  PERF ? 32'(m_flush)  : 32'd0);
    endtask

    task automatic model_reset();
        m_mode = M_RUN; m_pend = 0; m_stall = 0; m_freeze = 0; m_flush = 0;
    endtask

    task automatic eval_phase();
        @(negedge clk);
        model_eval();
        check_all();
    endtask

    task automatic commit_phase();
        @(posedge clk);
        if (rst_n) begin
            m_mode = n_mode;
            m_pend = n_pend;
            if (ev_stall && m_stall < CNT_MAX) m_stall++;
            if (bus.dmem_busywait && m_freeze < CNT_MAX) m_freeze++;
            if (bus.branch_taken && !bus.dmem_busywait && m_flush < CNT_MAX) m_flush++;
        end
        #1;
    endtask

    task automatic step();
        eval_phase();
        commit_phase();
    endtask

    task automatic idle();
        bus.id_rs1 = '0; bus.id_rs2 = '0; bus.id_rs1_used = 0; bus.id_rs2_used = 0;
        bus.ex_rs1 = '0; bus.ex_rs2 = '0; bus.ex_rd = '0; bus.ex_memRead = 0;
        bus.mem_rd = '0; bus.mem_writeEnable = 0; bus.wb_rd = '0; bus.wb_writeEnable = 0;
        bus.branch_taken = 0; bus.imem_busywait = 0; bus.dmem_busywait = 0;
    endtask

    task automatic randomize_inputs();
        bus.id_rs1 = REG_ADDR_W'($urandom_range(0, 3));
        bus.id_rs2 = REG_ADDR_W'($urandom_range(0, 3));
        bus.id_rs1_used = 1'($urandom_range(0, 1));
        bus.id_rs2_used = 1'($urandom_range(0, 1));
        bus.ex_rs1 = REG_ADDR_W'($urandom_range(0, 3));
        bus.ex_rs2 = REG_ADDR_W'($urandom_range(0, 3));
        bus.ex_rd  = REG_ADDR_W'($urandom_range(0, 3));
        bus.ex_memRead = ($urandom_range(0, 99) < 35);
        bus.mem_rd = REG_ADDR_W'($urandom_range(0, 3));
        bus.mem_writeEnable = 1'($urandom_range(0, 1));
        bus.wb_rd  = REG_ADDR_W'($urandom_range(0, 3));
        bus.wb_writeEnable = 1'($urandom_range(0, 1));
        bus.branch_taken  = ($urandom_range(0, 99) < 12);
        bus.imem_busywait = ($urandom_range(0, 99) < 35);
        bus.dmem_busywait = ($urandom_range(0, 99) < 15);
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        model_reset();
        #3;
        model_eval();
        check_all();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        step();

        // Load-use: lw x5 in EX, add reading x5 in ID.
        bus.ex_memRead = 1; bus.ex_rd = 5;
        bus.id_rs1 = 5; bus.id_rs1_used = 1; bus.id_rs2 = 6; bus.id_rs2_used = 1;
        eval_phase();
        check_eq("lu_pc_hold", 32'(bus.pc_hold), 32'd1);
        check_eq("lu_pr1_hold", 32'(bus.pr1_hold), 32'd1);
        check_eq("lu_pr2_flush", 32'(bus.pr2_flush), 32'd1);
        commit_phase();
        bus.ex_memRead = 0; bus.ex_rd = 0;
        eval_phase();
        check_eq("lu_released", 32'({bus.pc_hold, bus.pr1_hold, bus.pr2_flush}), 32'd0);
        commit_phase();
        check_eq("lu_stall_cnt", 32'(bus.stall_cnt), PERF ? 32'd1 : 32'd0);

        // Forwarding priority and x0 exclusion.
        idle();
        bus.mem_rd = 7; bus.mem_writeEnable = 1; bus.wb_rd = 7; bus.wb_writeEnable = 1;
        bus.ex_rs1 = 7;
        eval_phase(); check_eq("fwd_mem", 32'(bus.fwd_a_sel), 32'd1); commit_phase();
        bus.mem_rd = 0;
        eval_phase(); check_eq("fwd_wb", 32'(bus.fwd_a_sel), 32'd2); commit_phase();
        bus.wb_rd = 0;
        eval_phase(); check_eq("fwd_none", 32'(bus.fwd_a_sel), 32'd0); commit_phase();

        // Four-cycle data-cache freeze.
        idle();
        bus.dmem_busywait = 1;
        repeat (4) begin
            eval_phase();
            check_eq("frz_hold", 32'({bus.pc_hold, bus.pr1_hold, bus.pr2_hold, bus.pr3_hold}), 32'hF);
            check_eq("frz_bubble", 32'(bus.pr4_bubble), 32'd1);
            commit_phase();
        end
        bus.dmem_busywait = 0;
        eval_phase(); check_eq("frz_release", 32'(bus.pr4_bubble), 32'd0); commit_phase();
        check_eq("frz_cnt", 32'(bus.freeze_cnt), PERF ? 32'd4 : 32'd0);
        check_eq("frz_state_run", 32'(bus.state), 32'd0);

        // Branch redirect over an outstanding I-cache miss.
        bus.branch_taken = 1; bus.imem_busywait = 1;
        eval_phase(); check_eq("br_f1", 32'(bus.pr1_flush), 32'd1); commit_phase();
        bus.branch_taken = 0;
        repeat (3) begin
            eval_phase();
            check_eq("rd_state", 32'(bus.state), 32'd2);
            check_eq("rd_f1", 32'(bus.pr1_flush), 32'd1);
            commit_phase();
        end
        bus.imem_busywait = 0;
        eval_phase(); check_eq("rd_release_f1", 32'(bus.pr1_flush), 32'd1); commit_phase();
        eval_phase(); check_eq("rd_done_state", 32'(bus.state), 32'd0); commit_phase();

        // Data freeze overlapping a redirect.
        bus.branch_taken = 1; bus.imem_busywait = 1;
        step();
        bus.branch_taken = 0;
        step();
        bus.dmem_busywait = 1;
        eval_phase(); check_eq("ov_s0", 32'(bus.state), 32'd2); commit_phase();
        eval_phase(); check_eq("ov_s1", 32'(bus.state), 32'd1); commit_phase();
        bus.dmem_busywait = 0;
        eval_phase(); check_eq("ov_s2", 32'(bus.state), 32'd1);
        check_eq("ov_f1", 32'(bus.pr1_flush), 32'd1); commit_phase();
        eval_phase(); check_eq("ov_s3", 32'(bus.state), 32'd2); commit_phase();
        bus.imem_busywait = 0;
        step();
        eval_phase(); check_eq("ov_run", 32'(bus.state), 32'd0); commit_phase();

        // Asynchronous reset in the middle of a freeze.
        bus.dmem_busywait = 1;
        step(); step();
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        model_eval();
        check_all();
        check_eq("rst_async_state", 32'(bus.state), 32'd0);
        @(posedge clk);
        #1 idle();
        rst_n = 1'b1;
        step();

        repeat (3000) begin
            randomize_inputs();
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
